btn_debounce_pulse: RTL and testbench

- Conditions a raw mechanical push-button into clean single-cycle event pulses for the button press counter and LED logic.
- Input path: metastability synchroniser, then a debounce FSM, then optional hold/auto-repeat generation.
- Sits directly upstream of the press counter: counter increments once per press_pulse, and optionally on repeat_pulse.
- Replaces ad-hoc "hold for N cycles" counting in consumers.

---
 rtl/btn_pkg.sv | 23 ++
 rtl/btn_sync.sv | 28 ++
 rtl/btn_debounce_pulse.sv | 146 ++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning blocks.
//   btn_state_t : debounce/hold FSM state encoding
//   timer_width : width of the single saturating timer shared by all states
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        HOLD,
        DB_RELEASE
    } btn_state_t;

    // Enough bits to hold the largest of the three cycle counts.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Metastability synchroniser: a SYNC_STAGES-deep flop chain, cleared by reset.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; clears every stage to 0
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Turns a raw mechanical push-button into a clean debounced level plus
// single-cycle press / release / auto-repeat event pulses.
// Ports:
//   clk           : system clock
//   reset         : synchronous, active-high; aborts everything, no pulse
//   btn_raw       : asynchronous raw button, active-high
//   btn_level     : debounced button level
//   press_pulse   : one cycle on accepted press
//   release_pulse : one cycle on accepted release
//   repeat_pulse  : one cycle at the hold threshold, then every REPEAT_CYCLES
//   held          : high while in the hold (auto-repeat) region
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int CNT_W = timer_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Timer never wraps; with REPEAT_EN=0 it parks at full scale in PRESSED.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    logic       btn_s;
    btn_state_t state;
    logic [CNT_W-1:0] deb_cnt;

    btn_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_raw),
        .q    (btn_s)
    );

    // The debounce states enter with deb_cnt=1, so ">=" (rather than "==")
    // keeps DEBOUNCE_CYCLES=1 working: acceptance after one stable cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state   <= DB_PRESS;
                        deb_cnt <= CNT_ONE;
                    end
                end

                DB_PRESS: begin
                    if (!btn_s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt >= DEB_LAST) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                        deb_cnt     <= '0;
                    end else begin
                        deb_cnt <= sat_inc(deb_cnt);
                    end
                end

                PRESSED: begin
                    if (!btn_s) begin
                        state   <= DB_RELEASE;
                        deb_cnt <= CNT_ONE;
                    end else if ((REPEAT_EN != 0) && (deb_cnt >= HOLD_LAST)) begin
                        state        <= HOLD;
                        repeat_pulse <= 1'b1;
                        held         <= 1'b1;
                        deb_cnt      <= '0;
                    end else begin
                        deb_cnt <= sat_inc(deb_cnt);
                    end
                end

                HOLD: begin
                    // held deliberately stays high through DB_RELEASE.
                    if (!btn_s) begin
                        state   <= DB_RELEASE;
                        deb_cnt <= CNT_ONE;
                    end else if (deb_cnt >= REP_LAST) begin
                        repeat_pulse <= 1'b1;
                        deb_cnt      <= '0;
                    end else begin
                        deb_cnt <= sat_inc(deb_cnt);
                    end
                end

                DB_RELEASE: begin
                    if (btn_s) begin
                        // Release bounce: treat as still pressed, restart hold timing.
                        state   <= PRESSED;
                        held    <= 1'b0;
                        deb_cnt <= '0;
                    end else if (deb_cnt >= DEB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                        held          <= 1'b0;
                        deb_cnt       <= '0;
                    end else begin
                        deb_cnt <= sat_inc(deb_cnt);
                    end
                end

                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse with small timing parameters.
module tb_btn_debounce_pulse;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int LAT  = SYNC + DEB;   // drive-after-edge E -> pulse at edge E+LAT

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b0;

    logic btn_level, press_pulse, release_pulse, repeat_pulse, held;
    logic btn_level2, press_pulse2, release_pulse2, repeat_pulse2, held2;

    btn_debounce_pulse #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse), .held(held)
    );

    btn_debounce_pulse #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(0)
    ) dut_norep (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(btn_level2), .press_pulse(press_pulse2),
        .release_pulse(release_pulse2), .repeat_pulse(repeat_pulse2), .held(held2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int cyc;
        int kind;   // 0 press, 1 release, 2 repeat
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic raw;
        int   len;
        logic exp_level;
        int   press_at;     // offset from drive edge, -1 = none
        int   release_at;
    } vec_t;
    vec_t vecs[10];

    int n_press1 = 0, n_rel1 = 0;
    int n_press2 = 0, n_rel2 = 0, n_rep2 = 0, n_held2 = 0;
    int n_overlap = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic match_event(input int kind);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: unexpected kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != kind) begin
                n_fail++;
                $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    task automatic push_ev(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    // Any expected event whose cycle has passed was never produced.
    task automatic check_missed(input string name);
        int missed = 0;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            void'(exp_q.pop_front());
            missed++;
        end
        check(name, missed, 0);
    endtask

    always @(negedge clk) begin
        if (press_pulse)   begin match_event(0); n_press1++; end
        if (release_pulse) begin match_event(1); n_rel1++;   end
        if (repeat_pulse)  match_event(2);
        if (int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse) > 1) n_overlap++;
        if (press_pulse2)   n_press2++;
        if (release_pulse2) n_rel2++;
        if (repeat_pulse2)  n_rep2++;
        if (held2)          n_held2++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic run_seg(input int i);
        int e;
        e = cyc;
        btn_raw = vecs[i].raw;
        if (vecs[i].press_at >= 0)   push_ev(e + vecs[i].press_at, 0);
        if (vecs[i].release_at >= 0) push_ev(e + vecs[i].release_at, 1);
        repeat (vecs[i].len) step();
        check($sformatf("seg%0d btn_level", i), int'(btn_level), int'(vecs[i].exp_level));
        check($sformatf("seg%0d held", i), int'(held), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " btn_level"}, int'(btn_level), 0);
        check({name, " press"},     int'(press_pulse), 0);
        check({name, " release"},   int'(release_pulse), 0);
        check({name, " repeat"},    int'(repeat_pulse), 0);
        check({name, " held"},      int'(held), 0);
        check({name, " norep level"}, int'(btn_level2), 0);
    endtask

    initial begin
        int e, p, d, f, g;

        // clean press / release
        vecs[0] = '{1'b1, 10, 1'b1, LAT, -1};
        vecs[1] = '{1'b0, 10, 1'b0, -1, LAT};
        // 3-cycle glitch: never accepted
        vecs[2] = '{1'b1, 3, 1'b0, -1, -1};
        vecs[3] = '{1'b0, 10, 1'b0, -1, -1};
        // bounce 1,0,1,0 (2 cycles each) then stable high
        vecs[4] = '{1'b1, 2, 1'b0, -1, -1};
        vecs[5] = '{1'b0, 2, 1'b0, -1, -1};
        vecs[6] = '{1'b1, 2, 1'b0, -1, -1};
        vecs[7] = '{1'b0, 2, 1'b0, -1, -1};
        vecs[8] = '{1'b1, 10, 1'b1, LAT, -1};
        vecs[9] = '{1'b0, 10, 1'b0, -1, LAT};

        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check_all_zero("post-reset idle");

        for (int i = 0; i < 10; i++) run_seg(i);
        check_missed("table events");

        // long hold with auto-repeat
        e = cyc;
        btn_raw = 1'b1;
        p = e + LAT;
        push_ev(p, 0);
        for (int k = 0; k < 6; k++) push_ev(p + HOLD + REP * k, 2);
        wait_to(p + HOLD - 1);
        check("hold: held before threshold", int'(held), 0);
        step();
        check("hold: held at threshold", int'(held), 1);
        wait_to(p + 61);
        f = cyc;
        btn_raw = 1'b0;
        push_ev(f + LAT, 1);
        check("hold: norep held", int'(held2), 0);
        wait_to(f + LAT - 1);
        check("hold: held until release accepted", int'(held), 1);
        step();
        check("hold: held cleared on release", int'(held), 0);
        check("hold: level cleared on release", int'(btn_level), 0);
        wait_to(f + 12);
        check_missed("hold events");

        // short release bounce while in HOLD
        e = cyc;
        btn_raw = 1'b1;
        p = e + LAT;
        push_ev(p, 0);
        push_ev(p + HOLD, 2);
        wait_to(p + HOLD + 2);
        check("dip: held before dip", int'(held), 1);
        d = cyc;
        btn_raw = 1'b0;
        wait_to(d + 2);
        btn_raw = 1'b1;
        wait_to(d + SYNC + 2);
        check("dip: held during DB_RELEASE", int'(held), 1);
        step();
        check("dip: held cleared on bounce", int'(held), 0);
        check("dip: level stays high", int'(btn_level), 1);
        push_ev(d + SYNC + 3 + HOLD, 2);
        wait_to(d + SYNC + 4 + HOLD);
        check("dip: held again after new hold", int'(held), 1);
        g = cyc;
        btn_raw = 1'b0;
        push_ev(g + LAT, 1);
        wait_to(g + 12);
        check_missed("dip events");

        // reset in the middle of DB_PRESS: the press that would land at E+LAT is aborted
        e = cyc;
        btn_raw = 1'b1;
        wait_to(e + 4);
        reset = 1'b1;
        btn_raw = 1'b0;
        step();
        reset = 1'b0;
        check_all_zero("reset mid DB_PRESS");
        wait_to(e + 15);
        check_missed("reset DB_PRESS events");

        // reset in the middle of HOLD
        e = cyc;
        btn_raw = 1'b1;
        p = e + LAT;
        push_ev(p, 0);
        push_ev(p + HOLD, 2);
        wait_to(p + HOLD + 2);
        check("reset HOLD: held before", int'(held), 1);
        reset = 1'b1;
        btn_raw = 1'b0;
        step();
        reset = 1'b0;
        check_all_zero("reset mid HOLD");
        repeat (10) step();
        check_missed("reset HOLD events");

        // clean press after reset behaves as the first one
        run_seg(0);
        run_seg(1);
        check_missed("post-reset press events");

        check("pending events", exp_q.size(), 0);
        check("pulse overlap cycles", n_overlap, 0);
        check("norep repeat pulses", n_rep2, 0);
        check("norep held cycles", n_held2, 0);
        check("norep press count", n_press2, n_press1);
        check("norep release count", n_rel2, n_rel1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
